// File: rtl/neuron_tdm_pkg.sv
// Shared types, geometry and helpers for the time-multiplexed LogicNets layer sequencer.
// The default layer geometry is pinned here; index widths derive from it.
// Default connectivity spreads neuron fan-in slots round-robin over the input features.
package neuron_tdm_pkg;

  localparam int DEF_IN_WIDTH = 32;
  localparam int DEF_IN_BITS  = 2;
  localparam int DEF_FANIN    = 4;
  localparam int DEF_NEURONS  = 16;
  localparam int DEF_OUT_BITS = 2;

  localparam int FEAT_IDX_W = $clog2(DEF_IN_WIDTH / DEF_IN_BITS);
  localparam int NEUR_IDX_W = $clog2(DEF_NEURONS);
  localparam int LUT_ADDR_W = DEF_FANIN * DEF_IN_BITS;
  localparam int CFG_ADDR_W = $clog2(DEF_NEURONS * DEF_FANIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset-time feature index for neuron n, fan-in slot k.
  function automatic int default_conn(input int n, input int k, input int fanin, input int n_feat);
    return (n * fanin + k) % n_feat;
  endfunction

endpackage

// File: rtl/neuron_tdm_gather.sv
// Fan-in gather: picks FANIN features out of the captured input vector by table index.
// Purely combinational (zero latency); the caller registers the resulting LUT address.
// No handshake; the output follows in_vec_i/conn_i directly.
module neuron_tdm_gather #(
  parameter int IN_WIDTH = 32,
  parameter int IN_BITS  = 2,
  parameter int FANIN    = 4,
  parameter int FEAT_W   = 4
) (
  input  logic [IN_WIDTH-1:0]       in_vec_i,
  input  logic [FANIN*FEAT_W-1:0]   conn_i,
  output logic [FANIN*IN_BITS-1:0]  addr_o
);

  localparam int NFEAT = IN_WIDTH / IN_BITS;

  logic [IN_BITS-1:0] feat [NFEAT];

  for (genvar f = 0; f < NFEAT; f++) begin : g_feat
    assign feat[f] = in_vec_i[f*IN_BITS +: IN_BITS];
  end

  // Slot k of the address is the feature named by table entry k.
  always_comb begin
    addr_o = '0;
    for (int k = 0; k < FANIN; k++) begin
      addr_o[k*IN_BITS +: IN_BITS] = feat[conn_i[k*FEAT_W +: FEAT_W]];
    end
  end

endmodule

// File: rtl/neuron_tdm_scheduler.sv
// Evaluates one LogicNets layer through a shared LUT bank, one neuron per cycle.
// Accept to m_valid: NEURONS+2 edges; issue and capture are both registered (1-cycle LUT path).
// One vector in flight; s_ready low from accept until the output handshake completes.
module neuron_tdm_scheduler
  import neuron_tdm_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int FANIN    = DEF_FANIN,
  parameter int NEURONS  = DEF_NEURONS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [IN_WIDTH-1:0]           s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NEURONS*OUT_BITS-1:0]   m_data,
  output logic [NEUR_IDX_W-1:0]         lut_sel,
  output logic [LUT_ADDR_W-1:0]         lut_addr,
  input  logic [OUT_BITS-1:0]           lut_rdata,
  input  logic                          cfg_we,
  input  logic [CFG_ADDR_W-1:0]         cfg_addr,
  input  logic [FEAT_IDX_W-1:0]         cfg_data,
  output logic                          cfg_err,
  output logic                          busy
);

  localparam int NFEAT = IN_WIDTH / IN_BITS;
  localparam int TBL_N = NEURONS * FANIN;

  state_t                          state_q, state_d;
  logic   [IN_WIDTH-1:0]           in_q;
  logic   [NEUR_IDX_W-1:0]         cnt_q;
  logic                            issue_q;
  logic                            cap_q;
  logic   [NEUR_IDX_W-1:0]         lut_sel_q;
  logic   [LUT_ADDR_W-1:0]         lut_addr_q;
  logic   [NEURONS*OUT_BITS-1:0]   res_q;
  logic   [FEAT_IDX_W-1:0]         tbl_q [TBL_N];
  logic                            cfg_err_q;
  logic                            accept;
  logic                            last_cap;
  logic   [FANIN*FEAT_IDX_W-1:0]   conn;
  logic   [LUT_ADDR_W-1:0]         gather_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept in IDLE, leave EVAL on the last capture, leave DONE on the handshake.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_cap = cap_q && (lut_sel_q == NEUR_IDX_W'(NEURONS - 1));
    unique case (state_q)
      IDLE: if (s_valid) begin
        accept  = 1'b1;
        state_d = EVAL;
      end
      EVAL: if (last_cap) state_d = DONE;
      DONE: if (m_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Table entries of the neuron about to be issued.
  always_comb begin
    conn = '0;
    for (int k = 0; k < FANIN; k++) begin
      conn[k*FEAT_IDX_W +: FEAT_IDX_W] = tbl_q[CFG_ADDR_W'(int'(cnt_q) * FANIN + k)];
    end
  end

  neuron_tdm_gather #(
    .IN_WIDTH (IN_WIDTH),
    .IN_BITS  (IN_BITS),
    .FANIN    (FANIN),
    .FEAT_W   (FEAT_IDX_W)
  ) u_gather (
    .in_vec_i (in_q),
    .conn_i   (conn),
    .addr_o   (gather_addr)
  );

  // Issue pipeline: capture the vector, step the neuron counter, store LUT results one slot behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q       <= '0;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      cap_q      <= 1'b0;
      lut_sel_q  <= '0;
      lut_addr_q <= '0;
      res_q      <= '0;
    end else begin
      cap_q <= issue_q;
      if (accept) begin
        in_q    <= s_data;
        cnt_q   <= '0;
        issue_q <= 1'b1;
      end else if (issue_q) begin
        lut_sel_q  <= cnt_q;
        lut_addr_q <= gather_addr;
        if (cnt_q == NEUR_IDX_W'(NEURONS - 1)) begin
          cnt_q   <= '0;
          issue_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      for (int n = 0; n < NEURONS; n++) begin
        if (cap_q && (lut_sel_q == NEUR_IDX_W'(n))) res_q[n*OUT_BITS +: OUT_BITS] <= lut_rdata;
      end
    end
  end

  // Connectivity table: writable only while idle; a write at any other time is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= FEAT_IDX_W'(default_conn(i / FANIN, i % FANIN, FANIN, NFEAT));
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (state_q != IDLE);
      if (cfg_we && (state_q == IDLE)) tbl_q[cfg_addr] <= cfg_data;
    end
  end

  assign s_ready  = (state_q == IDLE);
  assign m_valid  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign m_data   = res_q;
  assign lut_sel  = lut_sel_q;
  assign lut_addr = lut_addr_q;
  assign cfg_err  = cfg_err_q;

endmodule
